// File: rtl/rssb_pkg.sv
// Shared types and the default RSSB program image that mem_ram loads after reset.
package rssb_pkg;

  typedef enum logic {INIT, READY} mem_state_t;

  localparam int IMG_LEN = 14;

  localparam logic [7:0] INIT_IMAGE [IMG_LEN] = '{
    8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd0,
    8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd3, 8'd1
  };

  // Words past the end of the image read as zero.
  function automatic logic [7:0] img_word(input logic [31:0] idx);
    logic [7:0] w;
    w = 8'd0;
    for (int i = 0; i < IMG_LEN; i++) begin
      if (idx == 32'(i)) w = INIT_IMAGE[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_ram_init_seq.sv
// Post-reset image loader for mem_ram: walks init_cnt over every word and
// raises busy until the last word has been written.
//   state | meaning
//   INIT  | loading INIT_IMAGE[init_cnt] into mem[init_cnt], requests ignored
//   READY | image loaded, core owns both ports
module mem_ram_init_seq
  import rssb_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [WIDTH-1:0]  init_data,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  mem_state_t        state, state_nxt;
  logic [ADDR_W-1:0] init_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= (init_cnt == LAST) ? '0 : init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_cnt == LAST) state_nxt = READY;
      READY:   state_nxt = READY;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    init_we   = (state == INIT);
    init_addr = init_cnt;
    init_data = WIDTH'(img_word(32'(init_cnt)));
    busy      = rst || (state == INIT);
  end

endmodule

// File: rtl/mem_ram.sv
// RSSB data memory: 1R/1W synchronous RAM, self-loaded from INIT_IMAGE after reset.
// Define MEM_RAM_FWD_EN for write-first forwarding on same-address collisions.
module mem_ram
  import rssb_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [WIDTH-1:0]  rd_data,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     busy,
  output logic                     err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [WIDTH-1:0]  init_data;
  logic              rd_acc, wr_acc, rd_ok, wr_ok, we;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0]  w_data, rd_word;

  mem_ram_init_seq #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .busy     (busy)
  );

  assign rd_ok  = {1'b0, rd_addr} < DEPTH_A;
  assign wr_ok  = {1'b0, wr_addr} < DEPTH_A;
  assign rd_acc = rd_en && !busy;
  assign wr_acc = wr_en && !busy;

  // The loader owns the write port while busy; core writes are only accepted afterwards.
  assign we     = init_we || (wr_acc && wr_ok);
  assign w_addr = init_we ? init_addr : wr_addr;
  assign w_data = init_we ? init_data : wr_data;

  always_ff @(posedge clk) begin
    if (we) mem[w_addr[IDX_W-1:0]] <= w_data;
  end

  always_comb begin
    rd_word = mem[rd_addr[IDX_W-1:0]];
`ifdef MEM_RAM_FWD_EN
    if (wr_acc && wr_ok && (wr_addr == rd_addr)) rd_word = wr_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      err      <= (rd_acc && !rd_ok) || (wr_acc && !wr_ok);
      if (rd_acc) rd_data <= rd_ok ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_mem_ram.sv
// Self-checking bench for mem_ram: directed scenarios plus a randomized phase
// checked against an array model of the memory.
module tb_mem_ram;

`ifdef MEM_RAM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [7:0] IMAGE [14] = '{
    8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd0,
    8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd3, 8'd1
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0, wr_en = 1'b0;
  logic [7:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, busy, err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model [16];
  logic [7:0] exp_data = '0;

  always #5 clk = ~clk;

  mem_ram dut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_model();
    for (int i = 0; i < 16; i++) model[i] = (i < 14) ? IMAGE[i] : 8'd0;
  endtask

  // Counts busy cycles after rst release while hammering the ports, which must be ignored.
  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      rd_en   = 1'($urandom_range(1, 0));
      wr_en   = 1'($urandom_range(1, 0));
      rd_addr = 8'($urandom_range(31, 0));
      wr_addr = 8'($urandom_range(31, 0));
      wr_data = 8'($urandom);
      step();
      n++;
      chk({tag, "_load_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_load_err"}, 32'(err), 32'd0);
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'd16);
  endtask

  task automatic op(input string tag, input logic re, input logic [7:0] ra,
                    input logic we, input logic [7:0] wa, input logic [7:0] wd);
    logic e_err;
    rd_en   = re;
    rd_addr = ra;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    step();
    e_err = (re && ra >= 8'd16) || (we && wa >= 8'd16);
    if (re) begin
      if (ra >= 8'd16)                exp_data = 8'd0;
      else if (we && wa == ra && FWD) exp_data = wd;
      else                            exp_data = model[ra[3:0]];
    end
    if (we && wa < 8'd16) model[wa[3:0]] = wd;
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk({tag, "_valid"}, 32'(rd_valid), 32'(re));
    chk({tag, "_data"}, 32'(rd_data), 32'(exp_data));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) op(tag, 1'b1, 8'(i), 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Image load and full readback
    rst = 1'b0;
    wait_load("load1");
    load_model();
    read_all("img");
    op("idle_after_burst", 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);

    // Read latency
    op("lat_rd5", 1'b1, 8'd5, 1'b0, 8'd0, 8'd0);
    chk("lat_rd5_value", 32'(rd_data), 32'd2);
    op("lat_drop", 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);

    // Write then read, signed result
    op("wr7", 1'b0, 8'd0, 1'b1, 8'd7, 8'hFB);
    op("rd7", 1'b1, 8'd7, 1'b0, 8'd0, 8'd0);
    checks++;
    assert ($signed(rd_data) === -8'sd5)
    else begin
      errors++;
      $error("FAIL rd7_signed observed=%0d expected=-5", $signed(rd_data));
    end

    // Same-address collision
    op("coll", 1'b1, 8'd3, 1'b1, 8'd3, 8'd9);
    chk("coll_value", 32'(rd_data), FWD ? 32'd9 : 32'd1);
    op("coll_after", 1'b1, 8'd3, 1'b0, 8'd0, 8'd0);
    chk("coll_after_value", 32'(rd_data), 32'd9);

    // Out-of-range read and write together
    op("oor", 1'b1, 8'd20, 1'b1, 8'd30, 8'hAA);
    op("oor_clear", 1'b0, 8'd0, 1'b0, 8'd0, 8'd0);
    read_all("oor_mem");

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      logic [7:0] ra, wa;
      ra = 8'($urandom_range(19, 0));
      wa = ($urandom_range(3, 0) == 0) ? ra : 8'($urandom_range(19, 0));
      op("rand", 1'($urandom_range(1, 0)), ra, 1'($urandom_range(1, 0)), wa, 8'($urandom));
    end
    read_all("rand_mem");

    // Reset mid-operation and mid-load
    op("wr0", 1'b0, 8'd0, 1'b1, 8'd0, 8'h55);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    chk("rst_mid_busy", 32'(busy), 32'd1);
    chk("rst_mid_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;
    wait_load("load2");
    load_model();
    exp_data = 8'd0;
    op("rd0_after_reload", 1'b1, 8'd0, 1'b0, 8'd0, 8'd0);
    read_all("reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
